// File: rtl/sprite_draw_queue_pkg.sv
// Shared types for the sprite draw command queue.
// Command layout, sequencer states and LCD limits.
package sprite_draw_queue_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 9;
  localparam int ROM_W = 4;
  localparam int CMD_W = X_W + Y_W + ROM_W;

  localparam int LCD_W = 240;
  localparam int LCD_H = 320;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_DRAWING = 2'd2
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [ROM_W-1:0] rom;
  } cmd_t;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Command FIFO with flush, sticky overflow and
// registered full/empty/count flags.
module draw_cmd_fifo
  import sprite_draw_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  cmd_t             wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output cmd_t             rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t             mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             ovf_q, ovf_d;
  logic             push_ok, pop_ok;

  // Full is the registered flag: a push seen while full is lost
  // even if a pop frees a slot on the same edge.
  assign push_ok = push_i & ~full_q & ~flush_i;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop_ok);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    ovf_d   = ovf_q | (push_i & full_q & ~flush_i);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/sprite_draw_queue.sv
// Sprite command queue and sequencer feeding the MIF
// sprite drawer through its ready/draw handshake.
module sprite_draw_queue
  import sprite_draw_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [X_W-1:0]   cmdX,
  input  logic [Y_W-1:0]   cmdY,
  input  logic [ROM_W-1:0] cmdROMId,
  input  logic             cmdPush,
  output logic             cmdFull,
  output logic [CNT_W-1:0] cmdCount,
  input  logic             flush,
  output logic             overflow,
  input  logic             drawReady,
  output logic             draw,
  output logic [X_W-1:0]   drawX,
  output logic [Y_W-1:0]   drawY,
  output logic [ROM_W-1:0] drawROMId,
  output logic             busy,
  output logic             allDone
);

  state_e state_q;
  cmd_t   cmd_q;
  logic   draw_q;
  logic   done_q;
  cmd_t   head;
  cmd_t   wcmd;
  logic   empty;
  logic   pop;

  assign wcmd = '{x: cmdX, y: cmdY, rom: cmdROMId};
  assign pop  = (state_q == S_IDLE) & ~empty & drawReady;

  draw_cmd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (cmdPush),
    .wdata_i    (wcmd),
    .pop_i      (pop),
    .flush_i    (flush),
    .rdata_o    (head),
    .full_o     (cmdFull),
    .empty_o    (empty),
    .count_o    (cmdCount),
    .overflow_o (overflow)
  );

  // Origin and draw are loaded on the same edge so the
  // drawer never samples a stale origin while draw=1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      draw_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cmd_q   <= head;
            draw_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!drawReady) begin
            draw_q  <= 1'b0;
            state_q <= S_DRAWING;
          end
        end
        S_DRAWING: begin
          if (drawReady) begin
            state_q <= S_IDLE;
            done_q  <= empty;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign draw      = draw_q;
  assign drawX     = cmd_q.x;
  assign drawY     = cmd_q.y;
  assign drawROMId = cmd_q.rom;
  assign busy      = (state_q != S_IDLE);
  assign allDone   = done_q;

endmodule

// File: tb/tb_sprite_draw_queue.sv
// Bench for sprite_draw_queue: directed table, corner
// sequences and a random run against a queue model.
module tb_sprite_draw_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clock;
  logic             reset;
  logic [7:0]       cmdX;
  logic [8:0]       cmdY;
  logic [3:0]       cmdROMId;
  logic             cmdPush;
  logic             cmdFull;
  logic [CNT_W-1:0] cmdCount;
  logic             flush;
  logic             overflow;
  logic             drawReady;
  logic             draw;
  logic [7:0]       drawX;
  logic [8:0]       drawY;
  logic [3:0]       drawROMId;
  logic             busy;
  logic             allDone;

  sprite_draw_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmdX      (cmdX),
    .cmdY      (cmdY),
    .cmdROMId  (cmdROMId),
    .cmdPush   (cmdPush),
    .cmdFull   (cmdFull),
    .cmdCount  (cmdCount),
    .flush     (flush),
    .overflow  (overflow),
    .drawReady (drawReady),
    .draw      (draw),
    .drawX     (drawX),
    .drawY     (drawY),
    .drawROMId (drawROMId),
    .busy      (busy),
    .allDone   (allDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drawer: manual level or an automatic contract-following model
  logic man_rdy = 1'b0;
  logic auto_rdy = 1'b1;
  logic auto_on = 1'b0;
  int   dst = 0;
  int   wcnt = 0;
  assign drawReady = auto_on ? auto_rdy : man_rdy;

  always @(negedge clock) begin
    if (!auto_on) begin
      dst = 0;
      auto_rdy = 1'b1;
    end else if (dst == 0) begin
      if (draw) begin
        auto_rdy = 1'b0;
        wcnt = $urandom_range(0, 6);
        dst = 1;
      end
    end else begin
      if (wcnt > 0) wcnt--;
      else if (!draw) begin
        auto_rdy = 1'b1;
        dst = 0;
      end
    end
  end

  // Reference model: queue of pending commands plus in-flight phase
  logic [20:0] mq[$];
  int          mph;
  logic        mdraw, mdone, movf;
  logic [20:0] mcur;

  typedef struct packed {
    logic [7:0] x;
    logic [8:0] y;
    logic [3:0] r;
    logic [3:0] c;
  } iss_t;
  iss_t issue_q[$];
  int   done_cnt = 0;
  logic draw_prev = 1'b0;

  task automatic model_init();
    mq.delete();
    mph = 0;
    mdraw = 1'b0;
    mdone = 1'b0;
    movf = 1'b0;
    mcur = '0;
    draw_prev = 1'b0;
  endtask

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      int   pre;
      logic ok;
      pre = mq.size();
      mdone = 1'b0;
      if (mph == 0) begin
        if (pre > 0 && drawReady) begin
          mcur = mq.pop_front();
          mdraw = 1'b1;
          mph = 1;
        end
      end else if (mph == 1) begin
        if (!drawReady) begin
          mdraw = 1'b0;
          mph = 2;
        end
      end else if (drawReady) begin
        mph = 0;
        mdone = (pre == 0);
      end
      if (flush) begin
        mq.delete();
        movf = 1'b0;
      end else if (cmdPush) begin
        if (pre == DEPTH) movf = 1'b1;
        else mq.push_back({cmdX, cmdY, cmdROMId});
      end
      ok = (draw === mdraw) && (busy === (mph != 0)) &&
           (allDone === mdone) && (overflow === movf) &&
           (cmdFull === (mq.size() == DEPTH)) &&
           (cmdCount === CNT_W'(mq.size())) &&
           ({drawX, drawY, drawROMId} === mcur);
      nvec++;
      if (!ok) begin
        nerr++;
        $display("FAIL model t=%0t: draw %b/%b busy %b/%b done %b/%b ovf %b/%b cnt %0d/%0d org %h/%h",
                 $time, draw, mdraw, busy, mph != 0, allDone, mdone,
                 overflow, movf, cmdCount, mq.size(),
                 {drawX, drawY, drawROMId}, mcur);
      end
      if (draw && !draw_prev)
        issue_q.push_back({drawX, drawY, drawROMId, cmdCount});
      if (allDone) done_cnt++;
      draw_prev = draw;
    end
  end

  typedef struct {
    logic       push, fl, rdy;
    logic [7:0] x;
    logic [8:0] y;
    logic [3:0] r;
    logic       e_draw, e_busy, e_done, e_full, e_ovf;
    logic [3:0] e_cnt;
    logic [7:0] ex;
    logic [8:0] ey;
    logic [3:0] er;
  } vec_t;

  function automatic vec_t mk(
    logic push, logic fl, logic rdy, logic [7:0] x, logic [8:0] y,
    logic [3:0] r, logic e_draw, logic e_busy, logic e_done,
    logic e_full, logic e_ovf, logic [3:0] e_cnt, logic [7:0] ex,
    logic [8:0] ey, logic [3:0] er);
    vec_t v;
    v.push = push; v.fl = fl; v.rdy = rdy;
    v.x = x; v.y = y; v.r = r;
    v.e_draw = e_draw; v.e_busy = e_busy; v.e_done = e_done;
    v.e_full = e_full; v.e_ovf = e_ovf; v.e_cnt = e_cnt;
    v.ex = ex; v.ey = ey; v.er = er;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    cmdPush = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clock);
    model_init();
    reset = 1'b0;
  endtask

  task automatic push_at_neg(input logic [7:0] x, input logic [8:0] y,
                             input logic [3:0] r);
    @(negedge clock);
    cmdPush = 1'b1;
    cmdX = x;
    cmdY = y;
    cmdROMId = r;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cmdPush = 1'b0;
    flush = 1'b0;
    cmdX = '0;
    cmdY = '0;
    cmdROMId = '0;
    #2;
    chk("rst_draw", 32'(draw), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cmdCount), 0);
    chk("rst_full", 32'(cmdFull), 0);
    chk("rst_org", 32'({drawX, drawY, drawROMId}), 0);
    do_reset();

    // Overflow, flush, then a single command
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1, 0, 0, 8'(i), 9'(i), 4'(i), 0, 0, 0,
                  i == 7, 0, 4'(i + 1), 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 9, 9, 9, 0, 0, 0, 1, 1, 8, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 10, 20, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 10, 20, 3);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10, 20, 3);
    for (int i = 0; i < 13; i++) begin
      logic ok;
      @(negedge clock);
      cmdPush = tbl[i].push;
      flush = tbl[i].fl;
      man_rdy = tbl[i].rdy;
      cmdX = tbl[i].x;
      cmdY = tbl[i].y;
      cmdROMId = tbl[i].r;
      tick();
      ok = draw === tbl[i].e_draw && busy === tbl[i].e_busy &&
           allDone === tbl[i].e_done && cmdFull === tbl[i].e_full &&
           overflow === tbl[i].e_ovf && cmdCount === tbl[i].e_cnt &&
           drawX === tbl[i].ex && drawY === tbl[i].ey &&
           drawROMId === tbl[i].er;
      nvec++;
      if (!ok) begin
        nerr++;
        $display("FAIL table[%0d]: draw=%b busy=%b done=%b full=%b ovf=%b cnt=%0d org=%0d,%0d,%0d required %b %b %b %b %b %0d %0d,%0d,%0d",
                 i, draw, busy, allDone, cmdFull, overflow, cmdCount,
                 drawX, drawY, drawROMId, tbl[i].e_draw, tbl[i].e_busy,
                 tbl[i].e_done, tbl[i].e_full, tbl[i].e_ovf,
                 tbl[i].e_cnt, tbl[i].ex, tbl[i].ey, tbl[i].er);
      end
    end
    @(negedge clock);
    cmdPush = 1'b0;
    flush = 1'b0;
    repeat (48) @(posedge clock);
    #1;
    chk("single_wait_busy", 32'(busy), 1);
    chk("single_wait_draw", 32'(draw), 0);
    @(negedge clock);
    man_rdy = 1'b1;
    tick();
    chk("single_done", 32'(allDone), 1);
    chk("single_busy0", 32'(busy), 0);
    tick();
    chk("single_done_pulse", 32'(allDone), 0);

    // Back-to-back three commands
    @(negedge clock);
    man_rdy = 1'b0;
    push_at_neg(5, 5, 1);
    push_at_neg(100, 200, 2);
    push_at_neg(239, 319, 15);
    @(negedge clock);
    cmdPush = 1'b0;
    tick();
    chk("b2b_cnt3", 32'(cmdCount), 3);
    issue_q.delete();
    done_cnt = 0;
    #1 auto_on = 1'b1;
    for (int i = 0; i < 300 && !(done_cnt > 0 && !busy); i++) tick();
    repeat (20) tick();
    chk("b2b_issues", 32'(issue_q.size()), 3);
    chk("b2b_done_once", 32'(done_cnt), 1);
    if (issue_q.size() == 3) begin
      chk("b2b_i0", 32'(issue_q[0]), 32'({8'd5, 9'd5, 4'd1, 4'd2}));
      chk("b2b_i1", 32'(issue_q[1]), 32'({8'd100, 9'd200, 4'd2, 4'd1}));
      chk("b2b_i2", 32'(issue_q[2]), 32'({8'd239, 9'd319, 4'd15, 4'd0}));
    end
    #1 auto_on = 1'b0;
    man_rdy = 1'b1;

    // Flush while a draw is in progress
    @(negedge clock);
    man_rdy = 1'b0;
    for (int i = 1; i <= 5; i++)
      push_at_neg(8'(i * 10), 9'(i * 20), 4'(i));
    @(negedge clock);
    cmdPush = 1'b0;
    man_rdy = 1'b1;
    tick();
    chk("fl_issue", 32'(draw), 1);
    chk("fl_cnt4", 32'(cmdCount), 4);
    @(negedge clock);
    man_rdy = 1'b0;
    tick();
    chk("fl_drawing", 32'({draw, busy}), 32'(2'b01));
    @(negedge clock);
    flush = 1'b1;
    tick();
    chk("fl_cnt0", 32'(cmdCount), 0);
    chk("fl_org", 32'({drawX, drawY, drawROMId}),
        32'({8'd10, 9'd20, 4'd1}));
    @(negedge clock);
    flush = 1'b0;
    repeat (5) tick();
    @(negedge clock);
    man_rdy = 1'b1;
    tick();
    chk("fl_done", 32'(allDone), 1);
    begin
      int n0;
      n0 = issue_q.size();
      repeat (10) tick();
      chk("fl_no_new_issue", 32'(issue_q.size() - n0), 0);
      chk("fl_draw0", 32'(draw), 0);
    end

    // Startup gating then async reset in ISSUE
    man_rdy = 1'b0;
    do_reset();
    push_at_neg(50, 60, 7);
    @(negedge clock);
    cmdPush = 1'b0;
    repeat (100) tick();
    chk("gate_draw0", 32'(draw), 0);
    chk("gate_cnt1", 32'(cmdCount), 1);
    @(negedge clock);
    man_rdy = 1'b1;
    tick();
    chk("gate_draw1", 32'(draw), 1);
    chk("gate_org", 32'({drawX, drawY, drawROMId}),
        32'({8'd50, 9'd60, 4'd7}));
    push_at_neg(1, 2, 3);
    push_at_neg(4, 5, 6);
    @(negedge clock);
    cmdPush = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_draw", 32'(draw), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cnt", 32'(cmdCount), 0);
    chk("arst_org", 32'({drawX, drawY, drawROMId}), 0);
    man_rdy = 1'b0;
    do_reset();

    // Random traffic against the model
    #2 auto_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      cmdPush = ($urandom_range(0, 99) < 55);
      cmdX = 8'($urandom_range(0, 239));
      cmdY = 9'($urandom_range(0, 319));
      cmdROMId = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 99) < 2);
    end
    @(negedge clock);
    cmdPush = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 400 && (busy || cmdCount != 0); i++) tick();
    chk("rand_drained", 32'({busy, cmdCount}), 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sprite_draw_queue.md
Name: sprite_draw_queue

Overview:
- Command queue and sequencer directly upstream of the MIF sprite drawer.
- Game/scene logic pushes sprite draw commands (origin x/y plus ROM id) into a FIFO at any rate.
- The block issues them one at a time to the drawer using its ready/draw handshake, and holds each command's coordinates stable until the drawer has accepted it.
- Reports per-frame completion back to the scene logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmdX  in  8  sprite origin x, 0..239
- cmdY  in  9  sprite origin y, 0..319
- cmdROMId  in  4  sprite ROM select
- cmdPush  in  1  enqueue {cmdX,cmdY,cmdROMId} this cycle
- cmdFull  out  1  FIFO full (registered)
- cmdCount  out  CNT_W  entries currently queued (excludes in-flight command)
- flush  in  1  synchronous clear of queued entries and overflow flag
- overflow  out  1  sticky; set when a push is dropped
- drawReady  in  1  drawer ready output
- draw  out  1  draw request to drawer
- drawX  out  8  drawer xOrigin
- drawY  out  9  drawer yOrigin
- drawROMId  out  4  drawer ROMId
- busy  out  1  high while a command is in flight (state != IDLE)
- allDone  out  1  one-cycle pulse: in-flight draw completed and FIFO empty

Behaviour:
- Reset values (async):
  - draw, busy, allDone, overflow, cmdFull = 0; cmdCount = 0.
  - drawX/drawY/drawROMId = 0; FIFO pointers = 0; state = IDLE.
- FIFO:
  - Push writes the tail entry.
  - cmdFull uses the registered full flag. A push while cmdFull=1 is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop with the FIFO non-full leaves cmdCount unchanged.
- Drawer contract:
  - The drawer shows ready=1 only after draw has been seen low.
  - It samples its origin inputs in the same cycle it first sees draw=1.
  - It drops ready the cycle after accepting, and re-raises ready only after finishing and seeing draw=0.
- State machine:
  - IDLE:
    - If FIFO non-empty and drawReady=1: register the head entry into drawX/drawY/drawROMId, pop, draw<=1, go to ISSUE.
    - Outputs and draw change on the same edge, so the origin is valid whenever draw=1.
  - ISSUE:
    - Hold draw=1 and the draw* outputs.
    - When drawReady=0 (accepted): draw<=0, go to DRAWING.
  - DRAWING:
    - draw* outputs are held.
    - When drawReady=1 (complete and ready again): go to IDLE.
    - If the FIFO is empty on that same edge, pulse allDone for 1 cycle.
  - The next command may issue on the cycle after returning to IDLE. Minimum issue-to-issue spacing is 3 cycles plus drawer time.
- At startup the drawer may hold drawReady=0; the block stays in IDLE with draw=0 until drawReady rises.
- Flush:
  - Empties the FIFO and clears overflow next edge.
  - Does not abort the in-flight command; state and draw* are unaffected.
  - A flush coinciding with a push: flush wins and the push is discarded without setting overflow.
  - A flush coinciding with an IDLE pop: the pop proceeds using the pre-flush head; the FIFO is empty afterwards.
- Reset mid-operation returns to IDLE immediately with draw=0. The drawer shares the reset.
- cmdCount and cmdFull update on the clock edge after a push or pop.

Decomposition:
- Shared package:
  - State encoding (IDLE=2'd0, ISSUE=2'd1, DRAWING=2'd2).
  - Field widths X_W=8, Y_W=9, ROM_W=4, CMD_W=21.
  - LCD limits 240/320.
- One sub-module: draw_cmd_fifo.
  - Synchronous CMD_W-wide FIFO with push/pop/flush, registered full/empty and count.
  - The top module contains only the sequencer FSM and output registers.

Test Plan:
- Single command:
  - Stimulus: push (x=10, y=20, rom=3) with drawReady=1.
  - Required: next-but-one edge draw=1, drawX=10, drawY=20, drawROMId=3. Model drops drawReady → draw=0 next edge. Model raises drawReady after 50 cycles → allDone one pulse, busy=0.
- Back-to-back:
  - Stimulus: push 3 commands (5,5,1), (100,200,2), (239,319,15).
  - Required: issued in order. Each draw rises only after the previous completion. cmdCount goes 3→2→1→0. allDone pulses once, after the third.
- Overflow (DEPTH=8):
  - Stimulus: drawReady=0; push 9 commands.
  - Required: cmdFull=1 after the 8th push, the 9th is dropped, overflow=1, cmdCount=8. Flush → cmdCount=0, overflow=0, cmdFull=0.
- Startup gating:
  - Stimulus: drawReady held 0 for 100 cycles with 1 entry queued.
  - Required: draw stays 0, cmdCount=1. drawReady=1 → draw=1 next edge.
- Flush mid-draw:
  - Stimulus: in DRAWING with 4 queued; assert flush.
  - Required: cmdCount=0, draw* unchanged. On completion allDone pulses and no new draw is issued.
- Async reset:
  - Stimulus: reset while in ISSUE.
  - Required: draw=0, busy=0, cmdCount=0, and drawX/drawY/drawROMId=0 without waiting for a clock edge.
